// File: rtl/line_buffer_controller_pkg.sv
// Shared CNN line-buffer definitions: window geometry and read-FSM encoding.
package line_buffer_controller_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int NUM_LINES   = KERNEL_SIZE + 1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/line_buffer_controller_wrap_counter.sv
// Modulo-MODULUS up-counter with synchronous clear; wrap flags the incrementing
// cycle on which the count returns to zero.
module wrap_counter #(
  parameter int MODULUS = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       inc,
  output logic [$clog2(MODULUS)-1:0] count,
  output logic                       wrap
);

  localparam int CW = $clog2(MODULUS);
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign wrap      = inc & w_at_last;
  assign count     = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/line_buffer_controller.sv
// Address/strobe controller for a ring of NUM_LINES row stores feeding a 3-row
// convolution window; tracks occupancy and sequences one row read at a time.
module line_buffer_controller #(
  parameter int IMG_WIDTH   = 28,
  parameter int KERNEL_SIZE = line_buffer_controller_pkg::KERNEL_SIZE,
  parameter int NUM_LINES   = line_buffer_controller_pkg::NUM_LINES
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     frame_start,
  input  logic                                     pixel_valid,
  output logic                                     pixel_ready,
  output logic [NUM_LINES-1:0]                     wr_en,
  output logic [$clog2(IMG_WIDTH)-1:0]             wr_col,
  output logic                                     rd_en,
  output logic [1:0]                               rd_line_sel,
  output logic [$clog2(IMG_WIDTH)-1:0]             rd_col,
  output logic                                     line_done,
  output logic [$clog2(NUM_LINES*IMG_WIDTH+1)-1:0] fill_level
);

  import line_buffer_controller_pkg::*;

  localparam int FW = $clog2(NUM_LINES*IMG_WIDTH+1);
  localparam logic [FW-1:0] CAP       = FW'(NUM_LINES * IMG_WIDTH);
  localparam logic [FW-1:0] RD_THRESH = FW'(KERNEL_SIZE * IMG_WIDTH);

  rd_state_e     r_state;
  logic [FW-1:0] r_fill;

  logic       w_ready;
  logic       w_accept;
  logic       w_rd;
  logic       w_wr_col_wrap;
  logic       w_rd_col_wrap;
  logic [1:0] w_wr_line;
  logic       w_wr_line_wrap;
  logic       w_rd_line_wrap;
  logic       w_unused;

  // Reset gates the accept so wr_en is quiet while reset_n is low.
  assign w_ready  = (r_fill < CAP);
  assign w_accept = pixel_valid & w_ready & ~frame_start & reset_n;
  assign w_rd     = (r_state == READ);
  assign w_unused = w_wr_line_wrap ^ w_rd_line_wrap;

  assign pixel_ready = w_ready;
  assign wr_en       = w_accept ? (NUM_LINES'(1) << w_wr_line) : '0;
  assign rd_en       = w_rd;
  assign line_done   = w_rd_col_wrap;
  assign fill_level  = r_fill;

  wrap_counter #(.MODULUS(IMG_WIDTH)) u_wr_col (
    .clock(clock), .reset_n(reset_n), .clear(frame_start),
    .inc(w_accept), .count(wr_col), .wrap(w_wr_col_wrap)
  );

  wrap_counter #(.MODULUS(NUM_LINES)) u_wr_line (
    .clock(clock), .reset_n(reset_n), .clear(frame_start),
    .inc(w_wr_col_wrap), .count(w_wr_line), .wrap(w_wr_line_wrap)
  );

  wrap_counter #(.MODULUS(IMG_WIDTH)) u_rd_col (
    .clock(clock), .reset_n(reset_n), .clear(frame_start),
    .inc(w_rd), .count(rd_col), .wrap(w_rd_col_wrap)
  );

  wrap_counter #(.MODULUS(NUM_LINES)) u_rd_line (
    .clock(clock), .reset_n(reset_n), .clear(frame_start),
    .inc(w_rd_col_wrap), .count(rd_line_sel), .wrap(w_rd_line_wrap)
  );

  // READ always runs a full row; leaving on the wrap guarantees an IDLE gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_fill  <= '0;
    end else if (frame_start) begin
      r_state <= IDLE;
      r_fill  <= '0;
    end else begin
      case (r_state)
        IDLE: if (r_fill >= RD_THRESH) r_state <= READ;
        READ: if (w_rd_col_wrap)       r_state <= IDLE;
        default:                       r_state <= IDLE;
      endcase
      if (w_accept && !w_rd) begin
        r_fill <= r_fill + 1'b1;
      end else if (!w_accept && w_rd && (r_fill != '0)) begin
        r_fill <= r_fill - 1'b1;
      end
    end
  end

endmodule
